tone_generator: RTL and testbench



---
 rtl/tone_generator.sv | 137 +++++++++++++
 tb/tb_tone_generator.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_generator.sv
`default_nettype none
// ============================================================================
// Module   : tone_generator
// Purpose  : Square-wave speaker driver; tone changes land on half-period
//            boundaries and a released note sustains, then ends low.
// Revision : 1.0
// ============================================================================
module tone_generator #(
    parameter int INPUT          = 50000000,
    parameter int WIDTH          = $clog2(INPUT / 131 / 2 - 1),
    parameter int SUSTAIN_CYCLES = INPUT / 4,
    parameter int SWIDTH         = (SUSTAIN_CYCLES > 0) ? $clog2(SUSTAIN_CYCLES + 1) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_on,
    input  logic [WIDTH-1:0] tone,
    output logic             speaker,
    output logic             playing
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PLAY     = 2'd1,
        SUSTAIN  = 2'd2,
        STOPPING = 2'd3
    } state_t;

    localparam bit                c_has_sustain = (SUSTAIN_CYCLES > 0);
    localparam logic [SWIDTH-1:0] c_sus_last    = SWIDTH'(c_has_sustain ? SUSTAIN_CYCLES - 1 : 0);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    cur_tone_q, cur_tone_d;
    logic [SWIDTH-1:0]   sus_cnt_q, sus_cnt_d;
    logic                speaker_q, speaker_d;
    logic                w_tp;
    logic                w_expire;

    assign w_tp    = (state_q != IDLE) && (cnt_q == cur_tone_q);
    assign speaker = speaker_q;
    assign playing = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_tone_d = cur_tone_q;
        sus_cnt_d  = sus_cnt_q;
        speaker_d  = speaker_q;
        w_expire   = 1'b0;

        if (state_q != IDLE) begin
            if (w_tp) begin
                cnt_d     = '0;
                speaker_d = ~speaker_q;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                speaker_d = 1'b0;
                // A zero count would toggle at clk/2, so it never starts a note
                if (key_on && (tone != '0)) begin
                    cur_tone_d = tone;
                    speaker_d  = 1'b1;
                    state_d    = PLAY;
                end
            end
            PLAY: begin
                if (w_tp && (tone != '0)) begin
                    cur_tone_d = tone;
                end
                if (!key_on) begin
                    if (c_has_sustain) begin
                        state_d   = SUSTAIN;
                        sus_cnt_d = '0;
                    end else begin
                        w_expire = 1'b1;
                    end
                end
            end
            SUSTAIN: begin
                if (key_on) begin
                    state_d   = PLAY;
                    sus_cnt_d = '0;
                end else if (sus_cnt_q == c_sus_last) begin
                    w_expire = 1'b1;
                end else begin
                    sus_cnt_d = sus_cnt_q + SWIDTH'(1);
                end
            end
            STOPPING: begin
                if (key_on) begin
                    state_d = PLAY;
                end else if (w_tp) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    speaker_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Stop now if already low (or the high half ends this very cycle);
        // otherwise let the running high half finish first.
        if (w_expire) begin
            if (!speaker_q || w_tp) begin
                state_d   = IDLE;
                cnt_d     = '0;
                speaker_d = 1'b0;
            end else begin
                state_d = STOPPING;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cur_tone_q <= '0;
            sus_cnt_q  <= '0;
            speaker_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_tone_q <= cur_tone_d;
            sus_cnt_q  <= sus_cnt_d;
            speaker_q  <= speaker_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tone_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_tone_generator
// Purpose  : Self-checking bench for tone_generator against a countdown model.
// Revision : 1.0
// ============================================================================
module tb_tone_generator;

    localparam int c_width = 8;
    localparam int c_sus   = 20;

    localparam int c_held  = 0;
    localparam int c_susm  = 1;
    localparam int c_stop  = 2;

    logic               clk;
    logic               rst_n;
    logic               key_on;
    logic [c_width-1:0] tone;
    logic               speaker;
    logic               playing;

    int n_vec;
    int n_err;
    int t;

    // Model: a note is either silent or sounding; a sounding note has a level,
    // the cycles left in the current half, the length of the next half and a mode.
    int m_active;
    int m_level;
    int m_left;
    int m_half;
    int m_mode;
    int m_sus_left;

    tone_generator #(
        .INPUT          (50000000),
        .WIDTH          (c_width),
        .SUSTAIN_CYCLES (c_sus),
        .SWIDTH         (5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_on  (key_on),
        .tone    (tone),
        .speaker (speaker),
        .playing (playing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", name, act, exp, t, $time);
        end
    endtask

    task automatic model_reset();
        m_active   = 0;
        m_level    = 0;
        m_left     = 0;
        m_half     = 0;
        m_mode     = c_held;
        m_sus_left = 0;
    endtask

    task automatic model_quiet();
        m_active = 0;
        m_level  = 0;
    endtask

    task automatic model_step();
        int  lvl0;
        int  mode0;
        bit  bnd;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_active == 0) begin
            if (key_on && tone != 0) begin
                m_active = 1;
                m_level  = 1;
                m_half   = int'(tone) + 1;
                m_left   = m_half;
                m_mode   = c_held;
            end
            return;
        end
        lvl0  = m_level;
        mode0 = m_mode;
        bnd   = (m_left == 1);
        if (bnd) begin
            m_level = 1 - m_level;
            if (mode0 == c_held && tone != 0) m_half = int'(tone) + 1;
            m_left = m_half;
        end else begin
            m_left = m_left - 1;
        end
        case (mode0)
            c_held: begin
                if (!key_on) begin
                    m_mode     = c_susm;
                    m_sus_left = c_sus;
                end
            end
            c_susm: begin
                if (key_on) m_mode = c_held;
                else if (m_sus_left == 1) begin
                    if (lvl0 == 0 || bnd) model_quiet();
                    else m_mode = c_stop;
                end else m_sus_left = m_sus_left - 1;
            end
            default: begin
                if (key_on) m_mode = c_held;
                else if (bnd) model_quiet();
            end
        endcase
    endtask

    // One clock: model advances on the edge, DUT compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        t++;
        chk("speaker", speaker, m_level);
        chk("playing", playing, m_active);
    endtask

    task automatic run_to(input int n);
        while (t < n) tick();
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        key_on = 1'b0;
        tone   = '0;
        tick();
        tick();
        chk("rst_speaker", speaker, 0);
        chk("rst_playing", playing, 0);
        rst_n = 1'b1;
        t     = 0;
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        t      = 0;
        rst_n  = 1'b1;
        key_on = 1'b0;
        tone   = '0;
        model_reset();
        #1;

        // Basic note and mid-half tone change
        do_reset();
        key_on = 1'b1;
        tone   = 8'd4;
        run_to(1);  chk("basic_rise", speaker, 1); chk("basic_play", playing, 1);
        run_to(5);  chk("basic_hi_end", speaker, 1);
        run_to(6);  chk("basic_fall", speaker, 0);
        run_to(10); chk("basic_lo_end", speaker, 0);
        run_to(11); chk("basic_rise2", speaker, 1);
        run_to(12); tone = 8'd9;
        run_to(15); chk("chg_hi_end", speaker, 1);
        run_to(16); chk("chg_fall", speaker, 0);
        run_to(25); chk("chg_lo_end", speaker, 0);
        run_to(26); chk("chg_rise", speaker, 1);
        run_to(35); chk("chg_hi2_end", speaker, 1);
        run_to(36); chk("chg_fall2", speaker, 0);

        // Release with speaker high at expiry
        do_reset();
        key_on = 1'b1;
        tone   = 8'd4;
        run_to(2);  key_on = 1'b0;
        run_to(6);  chk("rel_fall", speaker, 0);
        run_to(11); chk("rel_rise", speaker, 1);
        run_to(21); chk("rel_rise2", speaker, 1);
        run_to(25); chk("rel_last_hi", speaker, 1); chk("rel_last_play", playing, 1);
        run_to(26); chk("rel_end_spk", speaker, 0); chk("rel_end_play", playing, 0);
        run_to(40); chk("rel_quiet_spk", speaker, 0); chk("rel_quiet_play", playing, 0);

        // Re-press during sustain restarts the full sustain later
        do_reset();
        key_on = 1'b1;
        tone   = 8'd4;
        run_to(2);  key_on = 1'b0;
        run_to(12); key_on = 1'b1;
        run_to(16); chk("rp_fall", speaker, 0);
        run_to(21); chk("rp_rise", speaker, 1);
        run_to(30); chk("rp_play", playing, 1);
        run_to(31); chk("rp_rise2", speaker, 1);
        run_to(32); key_on = 1'b0;
        run_to(50); chk("rp_sustaining", playing, 1);
        run_to(55); chk("rp_last_hi", speaker, 1); chk("rp_last_play", playing, 1);
        run_to(56); chk("rp_end_spk", speaker, 0); chk("rp_end_play", playing, 0);

        // Zero tone never starts a note; zero during play keeps the old tone
        do_reset();
        key_on = 1'b1;
        tone   = 8'd0;
        run_to(5);  chk("zero_spk", speaker, 0); chk("zero_play", playing, 0);
        tone = 8'd4;
        t    = 0;
        run_to(1);  chk("zero_start", speaker, 1);
        run_to(2);  tone = 8'd0;
        run_to(11); chk("zero_keep_rise", speaker, 1);
        run_to(16); chk("zero_keep_fall", speaker, 0);
        run_to(21); chk("zero_keep_rise2", speaker, 1); chk("zero_keep_play", playing, 1);

        // Asynchronous reset in the middle of a high half
        tone = 8'd4;
        run_to(22);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_spk", speaker, 0);
        chk("async_play", playing, 0);
        model_reset();
        tick();
        rst_n = 1'b1;
        t     = 0;
        run_to(1);  chk("async_restart", speaker, 1); chk("async_restart_play", playing, 1);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 799) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                chk("rand_async_spk", speaker, 0);
                chk("rand_async_play", playing, 0);
            end
            if ($urandom_range(0, 31) == 0) key_on = ~key_on;
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 9) == 0) tone = 8'd0;
                else tone = 8'($urandom_range(1, 12));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
